l1i_cache: RTL
==============

Name: l1i_cache

Overview:
- Direct-mapped, read-only L1 instruction cache between the fetch stage and the memory system read-only (RO) port.
- Serves 32-bit instruction fetches, and refills whole lines as pipelined Wishbone reads of MW bits per beat.
- Hits return in one cycle, and back-to-back hits sustain one fetch per cycle.
- Supports a whole-cache invalidate (fence.i).

Parameters:
- XLEN, 32, fetch address width.
- AW, XLEN, bus address width.
- MW, 64, bus data width.
- LINES, 64, number of cache lines (power of 2).
- LINE_BEATS, 4, MW-bit beats per line (power of 2).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset, asynchronous, active-high.
- i_req  in  1  fetch request.
- i_pc  in  XLEN  fetch address; bits [1:0] are ignored.
- o_ready  out  1  request is accepted this cycle if i_req && o_ready.
- o_valid  out  1  response strobe, one cycle wide.
- o_insn  out  32  fetched instruction.
- o_err  out  1  bus error on this response.
- i_flush  in  1  invalidate all lines.
- o_ro_stb  out  1  bus strobe.
- o_ro_addr  out  AW  bus beat address, MW/8-aligned.
- i_ro_ack  in  1  beat acknowledge.
- i_ro_stall  in  1  bus not accepting strobe.
- i_ro_err  in  1  bus error.
- i_ro_data  in  MW  beat data.

Behaviour:
- Address split:
  - OFF = log2(LINE_BEATS*MW/8)
  - IDX = log2(LINES)
  - tag = i_pc[AW-1:OFF+IDX]
  - index = i_pc[OFF+IDX-1:OFF]
  - beat = i_pc[OFF-1:log2(MW/8)]
  - word select = i_pc[2] (MW=64); 0 selects data[31:0] (little-endian).
- Storage:
  - Valid bits in flops.
  - Tags and data in synchronous-read RAMs, read address taken from the accepted request.
- Reset (async): state=IDLE, all valid bits cleared, and o_valid, o_err, o_ro_stb, o_ro_addr, o_insn all 0.
- States: IDLE, LOOKUP, REFILL, RESPOND, FLUSH.
- IDLE:
  - o_ready=!i_flush.
  - Accept -> LOOKUP, latching pc.
  - i_flush -> FLUSH; flush beats i_req in the same cycle.
- LOOKUP:
  - Hit = valid[index] && tag match: o_valid=1 with o_insn this cycle.
  - o_ready=hit && !i_flush; a new accept stays in LOOKUP, otherwise -> IDLE (or FLUSH if i_flush).
  - Miss: o_ready=0 -> REFILL, with beat counters reset and valid[index] cleared.
- REFILL:
  - o_ro_stb=1 while issued<LINE_BEATS.
  - o_ro_addr = {tag,index,issued,zeros}; beats are issued in order starting at beat 0.
  - issued increments when stb && !i_ro_stall; address and stb hold while stalled.
  - Each i_ro_ack writes i_ro_data to data[index][acked] and increments acked.
  - The beat where acked==beat(pc) is also captured into a response register.
  - After the last ack: tag written, valid[index]=1 unless a flush is pending -> RESPOND.
  - i_ro_err in any REFILL cycle (including while stalled): stb drops the same cycle, the line stays invalid, remaining acks are ignored, go to RESPOND with err.
- RESPOND:
  - o_valid=1 for one cycle; o_err=1 if a bus error occurred, else o_insn from the captured beat.
  - Then -> FLUSH if a flush is pending, else IDLE.
- FLUSH: all valid bits cleared in one cycle -> IDLE, o_ready=0.
- i_flush during LOOKUP miss, REFILL or RESPOND is latched as pending and never dropped.
- Acks or errors arriving in IDLE, LOOKUP or FLUSH are ignored (stale beats after reset).
- Latency:
  - Hit: o_valid in the cycle after accept.
  - Miss: o_valid the cycle after the final ack.
- At most one outstanding miss.

Decomposition:
- Package l1i_pkg holds:
  - state enum (IDLE, LOOKUP, REFILL, RESPOND, FLUSH);
  - localparam functions for OFF, IDX and TAGW;
  - a typedef for the address split struct.
- Sub-module: l1i_data_ram, a 1R1W synchronous RAM of LINES*LINE_BEATS x MW.
  - The tag RAM is an instance of the same module with width TAGW.

Test Plan:
1. Cold miss, pc=0x104:
   - bus issues beats 0x100, 0x108, 0x110, 0x118;
   - acks carry D0..D3;
   - o_valid with o_insn=D0[63:32] the cycle after the 4th ack; o_err=0.
2. Back-to-back hits, then pc=0x100, 0x104, 0x118 on consecutive cycles:
   - o_valid on 3 consecutive cycles with D0[31:0], D0[63:32], D3[31:0];
   - no o_ro_stb.
3. Conflict: pc=0x2104 (index 8, same as 0x104):
   - refill from 0x2100;
   - a subsequent pc=0x104 misses again and refills 0x100.
4. Stall: i_ro_stall high for 3 cycles while the beat-1 strobe is up:
   - o_ro_addr stays 0x108;
   - exactly 4 accepted strobes;
   - response data correct.
5. Error: pc=0x40000000 with bus i_ro_stall=1, i_ro_err=1:
   - stb drops;
   - the next cycle gives o_valid=1, o_err=1;
   - a refetch misses again.
6. Flush and reset during refill:
   - i_flush after beat 1 ack: refill completes and responds, then all lines are invalid (0x104 misses).
   - i_reset after 2 acks: outputs go to 0 immediately, late acks are ignored, and the next fetch misses.

Source files
------------

// File: rtl/l1i_pkg.sv
// Shared types and geometry helpers for the L1 instruction cache.
// Holds the FSM state enum, address-split widths and the split layout.
package l1i_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    RESPOND,
    FLUSH
  } l1i_state_e;

  function automatic int l1i_off(input int line_beats, input int mw);
    return $clog2(line_beats * mw / 8);
  endfunction

  function automatic int l1i_idx(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int l1i_tagw(input int aw, input int lines,
                                  input int line_beats, input int mw);
    return aw - l1i_off(line_beats, mw) - l1i_idx(lines);
  endfunction

  // Default geometry: 32-bit address, 64 lines of 4 x 64-bit beats.
  localparam int L1I_OFF  = l1i_off(4, 64);
  localparam int L1I_IDX  = l1i_idx(64);
  localparam int L1I_TAGW = l1i_tagw(32, 64, 4, 64);

  typedef struct packed {
    logic [L1I_TAGW-1:0] tag;
    logic [L1I_IDX-1:0]  index;
    logic [1:0]          beat;
    logic                word;
    logic [1:0]          byte_off;
  } l1i_addr_t;

endpackage

// File: rtl/l1i_data_ram.sv
// 1R1W synchronous RAM; read data appears the cycle after i_re.
// Ports: i_clk, read (i_re/i_raddr/o_rdata), write (i_we/i_waddr/i_wdata).
module l1i_data_ram #(
  parameter int W     = 64,
  parameter int DEPTH = 256,
  parameter int AWD   = $clog2(DEPTH)
) (
  input  logic           i_clk,
  input  logic           i_re,
  input  logic [AWD-1:0] i_raddr,
  output logic [W-1:0]   o_rdata,
  input  logic           i_we,
  input  logic [AWD-1:0] i_waddr,
  input  logic [W-1:0]   i_wdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= mem_q[i_raddr];
  end

endmodule

// File: rtl/l1i_cache.sv
// Direct-mapped read-only L1 I-cache with pipelined Wishbone line refill.
// Ports: fetch (i_req/i_pc/o_ready/o_valid/o_insn/o_err), i_flush, RO bus.
module l1i_cache
  import l1i_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int AW         = XLEN,
  parameter int MW         = 64,
  parameter int LINES      = 64,
  parameter int LINE_BEATS = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_ready,
  output logic            o_valid,
  output logic [31:0]     o_insn,
  output logic            o_err,
  input  logic            i_flush,
  output logic            o_ro_stb,
  output logic [AW-1:0]   o_ro_addr,
  input  logic            i_ro_ack,
  input  logic            i_ro_stall,
  input  logic            i_ro_err,
  input  logic [MW-1:0]   i_ro_data
);

  localparam int OFF  = l1i_off(LINE_BEATS, MW);
  localparam int IDX  = l1i_idx(LINES);
  localparam int TAGW = l1i_tagw(AW, LINES, LINE_BEATS, MW);
  localparam int BOFF = $clog2(MW / 8);
  localparam int BW   = $clog2(LINE_BEATS);
  localparam int WSW  = $clog2(MW / 32);

  l1i_state_e state_q, state_d;

  logic [XLEN-1:2]  pc_q;
  logic [BW:0]      issued_q;
  logic [BW:0]      acked_q;
  logic             err_q;
  logic             pend_q;
  logic [MW-1:0]    resp_q;
  logic [LINES-1:0] valid_q;

  logic [TAGW-1:0] tag_q;
  logic [IDX-1:0]  idx_q;
  logic [BW-1:0]   beat_q;
  logic [WSW-1:0]  word_q;
  logic [IDX-1:0]  idx_i;
  logic [BW-1:0]   beat_i;
  logic [TAGW-1:0] tag_rd;
  logic [MW-1:0]   data_rd;
  logic            accept;
  logic            hit;
  logic            last_ack;
  logic            data_we;
  logic            tag_we;
  logic            unused_pc;

  assign unused_pc = ^i_pc[1:0];

  assign tag_q  = pc_q[AW-1:OFF+IDX];
  assign idx_q  = pc_q[OFF+IDX-1:OFF];
  assign beat_q = pc_q[OFF-1:BOFF];
  assign word_q = pc_q[BOFF-1:2];
  assign idx_i  = i_pc[OFF+IDX-1:OFF];
  assign beat_i = i_pc[OFF-1:BOFF];

  assign accept   = i_req && o_ready;
  assign hit      = valid_q[idx_q] && (tag_rd == tag_q);
  assign last_ack = i_ro_ack && (acked_q[BW-1:0] == {BW{1'b1}});
  // An error beat never lands in the arrays.
  assign data_we  = (state_q == REFILL) && i_ro_ack && !i_ro_err;
  assign tag_we   = data_we && last_ack;

  function automatic logic [31:0] pick(input logic [MW-1:0] d,
                                       input logic [WSW-1:0] w);
    return d[w*32 +: 32];
  endfunction

  l1i_data_ram #(
    .W     (MW),
    .DEPTH (LINES * LINE_BEATS)
  ) u_data (
    .i_clk   (i_clk),
    .i_re    (accept),
    .i_raddr ({idx_i, beat_i}),
    .o_rdata (data_rd),
    .i_we    (data_we),
    .i_waddr ({idx_q, acked_q[BW-1:0]}),
    .i_wdata (i_ro_data)
  );

  l1i_data_ram #(
    .W     (TAGW),
    .DEPTH (LINES)
  ) u_tag (
    .i_clk   (i_clk),
    .i_re    (accept),
    .i_raddr (idx_i),
    .o_rdata (tag_rd),
    .i_we    (tag_we),
    .i_waddr (idx_q),
    .i_wdata (tag_q)
  );

  always_comb begin
    state_d   = state_q;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_err     = 1'b0;
    o_insn    = '0;
    o_ro_stb  = 1'b0;
    o_ro_addr = '0;
    unique case (state_q)
      IDLE: begin
        o_ready = !i_flush;
        if (i_flush)    state_d = FLUSH;
        else if (i_req) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          o_valid = 1'b1;
          o_insn  = pick(data_rd, word_q);
          o_ready = !i_flush;
          if (i_flush)    state_d = FLUSH;
          else if (i_req) state_d = LOOKUP;
          else            state_d = IDLE;
        end else begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        // A bus error kills the strobe in the same cycle.
        o_ro_stb = !issued_q[BW] && !i_ro_err;
        if (o_ro_stb)
          o_ro_addr = {tag_q, idx_q, issued_q[BW-1:0], {BOFF{1'b0}}};
        if (i_ro_err || last_ack) state_d = RESPOND;
      end
      RESPOND: begin
        o_valid = 1'b1;
        o_err   = err_q;
        o_insn  = err_q ? 32'd0 : pick(resp_q, word_q);
        state_d = (pend_q || i_flush) ? FLUSH : IDLE;
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      issued_q <= '0;
      acked_q  <= '0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      resp_q   <= '0;
      valid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) pc_q <= i_pc[XLEN-1:2];
      unique case (state_q)
        LOOKUP: begin
          if (!hit) begin
            issued_q       <= '0;
            acked_q        <= '0;
            err_q          <= 1'b0;
            valid_q[idx_q] <= 1'b0;
            pend_q         <= pend_q | i_flush;
          end
        end
        REFILL: begin
          pend_q <= pend_q | i_flush;
          if (o_ro_stb && !i_ro_stall) issued_q <= issued_q + 1'b1;
          if (i_ro_err) begin
            err_q <= 1'b1;
          end else if (i_ro_ack) begin
            acked_q <= acked_q + 1'b1;
            if (acked_q[BW-1:0] == beat_q) resp_q <= i_ro_data;
            // A flush seen during the fill leaves the line invalid.
            if (last_ack) valid_q[idx_q] <= !(pend_q || i_flush);
          end
        end
        RESPOND: pend_q <= pend_q | i_flush;
        FLUSH: begin
          valid_q <= '0;
          pend_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
